// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;

   localparam int WIDTH_DEF = 16;

   // FILL is this bit replicated across the word.
   localparam logic FILL_BIT = 1'b1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   function automatic int cnt_width(input int width);
      if (width <= 2) begin
         return 1;
      end else begin
         return $clog2(width);
      end
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Pin synchronizer with a registered copy for edge detection.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain_r;
   logic              prev_r;

   // Synchronizer chain and one-cycle-delayed copy of its output.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain_r <= {STAGES{RST_VAL}};
         prev_r  <= RST_VAL;
      end else begin
         chain_r <= {chain_r[STAGES-2:0], din};
         prev_r  <= chain_r[STAGES-1];
      end
   end

   assign dout = chain_r[STAGES-1];
   assign rise = chain_r[STAGES-1] & ~prev_r;
   assign fall = ~chain_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder, MSB first, with a one-deep transmit buffer and a
// receive strobe. Pins are oversampled on clk.
module spi_peripheral
   import spi_pkg::*;
#(
   parameter int               WIDTH       = WIDTH_DEF,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] FILL        = {WIDTH{FILL_BIT}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             SCK,
   input  logic             CSX,
   input  logic             SDI,
   output logic             SDO,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             underrun,
   output logic             frame_err
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic sck_level_unused_s, sck_rise_s, sck_fall_s;
   logic csx_s, csx_rise_s, csx_fall_s;
   logic sdi_s, sdi_rise_unused_s, sdi_fall_unused_s;

   state_t                 state_r, state_nxt_s;
   logic [CW-1:0]          bit_cnt_r, bit_cnt_nxt_s;
   logic [WIDTH-1:0]       tx_shift_r, tx_shift_nxt_s;
   logic [WIDTH-1:0]       rx_shift_r, rx_shift_nxt_s;
   logic [WIDTH-1:0]       rx_data_r, rx_data_nxt_s, rx_word_s;
   logic [WIDTH-1:0]       tx_buf_r;
   logic                   tx_full_r, tx_full_nxt_s, wr_s, clr_full_s;
   logic                   pend_r, pend_nxt_s, pend_fill_r, pend_fill_nxt_s;
   logic                   word_done_r, word_done_nxt_s, rx_valid_r;
   logic                   underrun_r, underrun_nxt_s;
   logic                   frame_err_r, frame_err_nxt_s;
   logic                   sdo_r, armed_r;
   logic [SYNC_STAGES-1:0] settle_r;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .clk(clk), .rst(rst), .din(SCK),
      .dout(sck_level_unused_s), .rise(sck_rise_s), .fall(sck_fall_s)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csx (
      .clk(clk), .rst(rst), .din(CSX),
      .dout(csx_s), .rise(csx_rise_s), .fall(csx_fall_s)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
      .clk(clk), .rst(rst), .din(SDI),
      .dout(sdi_s), .rise(sdi_rise_unused_s), .fall(sdi_fall_unused_s)
   );

   assign wr_s      = tx_valid & ~tx_full_r;
   assign rx_word_s = {rx_shift_r[WIDTH-2:0], sdi_s};

   // Next-state, datapath and strobe decode. A word-boundary load is held
   // tentative until the first SCK rise of the new word, so the trailing SCK
   // fall of a frame neither consumes the buffer nor reports an underrun.
   always_comb begin
      state_nxt_s     = state_r;
      bit_cnt_nxt_s   = bit_cnt_r;
      tx_shift_nxt_s  = tx_shift_r;
      rx_shift_nxt_s  = rx_shift_r;
      rx_data_nxt_s   = rx_data_r;
      pend_nxt_s      = pend_r;
      pend_fill_nxt_s = pend_fill_r;
      word_done_nxt_s = 1'b0;
      underrun_nxt_s  = 1'b0;
      frame_err_nxt_s = 1'b0;
      clr_full_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (csx_fall_s && armed_r) begin
               state_nxt_s    = SHIFT;
               bit_cnt_nxt_s  = CNT_ZERO;
               pend_nxt_s     = 1'b0;
               tx_shift_nxt_s = tx_full_r ? tx_buf_r : FILL;
               clr_full_s     = tx_full_r;
               underrun_nxt_s = ~tx_full_r;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            if (csx_rise_s) begin
               state_nxt_s     = IDLE;
               bit_cnt_nxt_s   = CNT_ZERO;
               pend_nxt_s      = 1'b0;
               frame_err_nxt_s = (bit_cnt_r != CNT_ZERO);
            end else if (sck_rise_s) begin
               rx_shift_nxt_s = rx_word_s;
               pend_nxt_s     = 1'b0;
               clr_full_s     = pend_r & ~pend_fill_r;
               underrun_nxt_s = pend_r & pend_fill_r;
               if (bit_cnt_r == CNT_LAST) begin
                  bit_cnt_nxt_s   = CNT_ZERO;
                  rx_data_nxt_s   = rx_word_s;
                  word_done_nxt_s = 1'b1;
               end else begin
                  bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
               end
            end else if (sck_fall_s) begin
               if (bit_cnt_r != CNT_ZERO) begin
                  tx_shift_nxt_s = {tx_shift_r[WIDTH-2:0], 1'b0};
               end else begin
                  tx_shift_nxt_s  = tx_full_r ? tx_buf_r : FILL;
                  pend_nxt_s      = 1'b1;
                  pend_fill_nxt_s = ~tx_full_r;
               end
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
      if (wr_s) begin
         tx_full_nxt_s = 1'b1;
      end else if (clr_full_s) begin
         tx_full_nxt_s = 1'b0;
      end else begin
         tx_full_nxt_s = tx_full_r;
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         bit_cnt_r   <= CNT_ZERO;
         tx_shift_r  <= {WIDTH{1'b0}};
         rx_shift_r  <= {WIDTH{1'b0}};
         rx_data_r   <= {WIDTH{1'b0}};
         tx_buf_r    <= {WIDTH{1'b0}};
         tx_full_r   <= 1'b0;
         pend_r      <= 1'b0;
         pend_fill_r <= 1'b0;
         word_done_r <= 1'b0;
         rx_valid_r  <= 1'b0;
         underrun_r  <= 1'b0;
         frame_err_r <= 1'b0;
         sdo_r       <= 1'b0;
         armed_r     <= 1'b0;
         settle_r    <= {SYNC_STAGES{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         bit_cnt_r   <= bit_cnt_nxt_s;
         tx_shift_r  <= tx_shift_nxt_s;
         rx_shift_r  <= rx_shift_nxt_s;
         rx_data_r   <= rx_data_nxt_s;
         tx_buf_r    <= wr_s ? tx_data : tx_buf_r;
         tx_full_r   <= tx_full_nxt_s;
         pend_r      <= pend_nxt_s;
         pend_fill_r <= pend_fill_nxt_s;
         word_done_r <= word_done_nxt_s;
         rx_valid_r  <= word_done_r;
         underrun_r  <= underrun_nxt_s;
         frame_err_r <= frame_err_nxt_s;
         sdo_r       <= (state_nxt_s == SHIFT) ? tx_shift_nxt_s[WIDTH-1] : 1'b0;
         // Arming waits until the synchronizer has flushed its reset value,
         // so a CSX held low through reset cannot open a frame.
         settle_r    <= {settle_r[SYNC_STAGES-2:0], 1'b1};
         armed_r     <= armed_r | (csx_s & settle_r[SYNC_STAGES-1]);
      end
   end

   assign SDO       = sdo_r;
   assign tx_ready  = ~tx_full_r;
   assign rx_data   = rx_data_r;
   assign rx_valid  = rx_valid_r;
   assign underrun  = underrun_r;
   assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_peripheral.sv
// Randomized bench for spi_peripheral: drives SPI mode-0 frames at clk/8 and
// checks SDO words, received words and strobes against a word-level model.
module tb_spi_peripheral;

   localparam int         W      = 16;
   localparam logic [W-1:0] FILL_W = 16'hFFFF;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         SCK = 1'b0;
   logic         CSX = 1'b1;
   logic         SDI = 1'b0;
   logic         SDO;
   logic [W-1:0] tx_data = 16'h0000;
   logic         tx_valid = 1'b0;
   logic         tx_ready;
   logic [W-1:0] rx_data;
   logic         rx_valid, underrun, frame_err;

   always #5 clk = ~clk;

   spi_peripheral #(.WIDTH(W), .SYNC_STAGES(2), .FILL(FILL_W)) dut (
      .clk(clk), .rst(rst), .SCK(SCK), .CSX(CSX), .SDI(SDI), .SDO(SDO),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun),
      .frame_err(frame_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Strobe monitor
   int           n_rxv = 0, n_und = 0, n_ferr = 0;
   logic [W-1:0] rx_seen[$];
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) begin
            n_rxv++;
            rx_seen.push_back(rx_data);
         end
         if (underrun) n_und++;
         if (frame_err) n_ferr++;
      end
   end

   // Word-level model: buffer contents and last complete received word
   logic [W-1:0] model_buf[$];
   logic [W-1:0] model_rx = 16'h0000;

   logic [W-1:0] f_sdi[4];
   bit           f_wr[4];
   logic [W-1:0] f_wrw[4];

   task automatic tx_write(input logic [W-1:0] w);
      check_val("tx_ready_before_write", W'(tx_ready), W'(1'b1));
      tx_data  = w;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      model_buf.push_back(w);
   endtask

   // nwords full words, then ab (0..W-1) bits of a partial word before CSX rises
   task automatic run_frame(input int nwords, input int ab);
      int           nstart, nbits, exp_und, und0, fe0, rx0;
      logic [W-1:0] exp_tx, miso, mask, ones;
      logic [W-1:0] exp_rx[$];
      ones = 16'hFFFF;
      exp_und = 0;
      und0 = n_und; fe0 = n_ferr; rx0 = n_rxv;
      rx_seen.delete();
      CSX = 1'b0;
      repeat (4) @(negedge clk);
      nstart = nwords + ((ab > 0) ? 1 : 0);
      if (nstart == 0) nstart = 1;
      for (int w = 0; w < nstart; w++) begin
         if (model_buf.size() > 0) begin
            exp_tx = model_buf.pop_front();
         end else begin
            exp_tx = FILL_W;
            exp_und++;
         end
         nbits = (w < nwords) ? W : ab;
         miso = 16'h0000;
         for (int i = W - 1; i >= W - nbits; i--) begin
            SDI = f_sdi[w][i];
            repeat (4) @(negedge clk);
            miso[i] = SDO;
            SCK = 1'b1;
            if (f_wr[w] && i == W - 3 && model_buf.size() == 0) begin
               tx_write(f_wrw[w]);
               repeat (3) @(negedge clk);
            end else begin
               repeat (4) @(negedge clk);
            end
            SCK = 1'b0;
         end
         if (nbits > 0) begin
            mask = ones << (W - nbits);
            check_val("sdo_word", miso & mask, exp_tx & mask);
         end
         if (nbits == W) begin
            exp_rx.push_back(f_sdi[w]);
            model_rx = f_sdi[w];
         end
      end
      repeat (4) @(negedge clk);
      CSX = 1'b1;
      repeat (12) @(negedge clk);
      check_val("underrun_count", W'(n_und - und0), W'(exp_und));
      check_val("frame_err_count", W'(n_ferr - fe0), W'((ab > 0) ? 1 : 0));
      check_val("rx_valid_count", W'(n_rxv - rx0), W'(nwords));
      for (int k = 0; k < exp_rx.size() && k < rx_seen.size(); k++)
         check_val("rx_word", rx_seen[k], exp_rx[k]);
      check_val("rx_data_held", rx_data, model_rx);
      check_val("sdo_idle", W'(SDO), W'(1'b0));
      check_val("tx_ready_after", W'(tx_ready), W'(model_buf.size() == 0));
   endtask

   initial begin
      logic         sdo_or;
      int           und_s, fe_s, rx_s;
      for (int k = 0; k < 4; k++) f_wr[k] = 1'b0;

      // Reset held with CSX low: reset values, then no frame may start
      CSX = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_sdo", W'(SDO), W'(1'b0));
      check_val("rst_tx_ready", W'(tx_ready), W'(1'b1));
      check_val("rst_rx_data", rx_data, 16'h0000);
      check_val("rst_rx_valid", W'(rx_valid), W'(1'b0));
      check_val("rst_underrun", W'(underrun), W'(1'b0));
      check_val("rst_frame_err", W'(frame_err), W'(1'b0));
      rst = 1'b0;
      repeat (6) @(negedge clk);
      sdo_or = 1'b0;
      for (int i = 0; i < W; i++) begin
         SDI = 1'($urandom);
         repeat (4) @(negedge clk);
         sdo_or = sdo_or | SDO;
         SCK = 1'b1;
         repeat (4) @(negedge clk);
         SCK = 1'b0;
      end
      repeat (10) @(negedge clk);
      check_val("unarmed_sdo", W'(sdo_or), W'(1'b0));
      check_val("unarmed_rx_valid", W'(n_rxv), W'(0));
      check_val("unarmed_underrun", W'(n_und), W'(0));
      CSX = 1'b1;
      repeat (8) @(negedge clk);

      // Buffered word out, 0x1234 in
      tx_write(16'hA55A);
      f_sdi[0] = 16'h1234;
      run_frame(1, 0);

      // Empty buffer: FILL out
      f_sdi[0] = 16'h00FF;
      run_frame(1, 0);

      // Two-word burst, second word written during the first
      tx_write(16'h1111);
      f_sdi[0] = W'($urandom);
      f_sdi[1] = W'($urandom);
      f_wr[0] = 1'b1;
      f_wrw[0] = 16'h2222;
      run_frame(2, 0);
      f_wr[0] = 1'b0;

      // Abort after 7 bits, then a clean frame
      f_sdi[0] = W'($urandom);
      run_frame(0, 7);
      f_sdi[0] = W'($urandom);
      run_frame(1, 0);

      // Reset mid-word
      CSX = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         SDI = 1'($urandom);
         repeat (4) @(negedge clk);
         SCK = 1'b1;
         if (i == 2) begin
            tx_write(16'h5A5A);
            repeat (3) @(negedge clk);
         end else begin
            repeat (4) @(negedge clk);
         end
         SCK = 1'b0;
      end
      SCK = 1'b1;
      repeat (2) @(negedge clk);
      und_s = n_und; fe_s = n_ferr; rx_s = n_rxv;
      rst = 1'b1;
      @(negedge clk);
      check_val("midrst_sdo", W'(SDO), W'(1'b0));
      check_val("midrst_tx_ready", W'(tx_ready), W'(1'b1));
      check_val("midrst_rx_data", rx_data, 16'h0000);
      check_val("midrst_strobes", W'({rx_valid, underrun, frame_err}), W'(3'b000));
      CSX = 1'b1;
      SCK = 1'b0;
      rst = 1'b0;
      model_buf.delete();
      model_rx = 16'h0000;
      repeat (12) @(negedge clk);
      check_val("midrst_no_rx_valid", W'(n_rxv - rx_s), W'(0));
      check_val("midrst_no_frame_err", W'(n_ferr - fe_s), W'(0));
      check_val("midrst_no_underrun", W'(n_und - und_s), W'(0));

      // Randomized frames
      for (int f = 0; f < 30; f++) begin
         int nw, ab;
         nw = $urandom_range(0, 3);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : 0;
         for (int k = 0; k < 4; k++) begin
            f_sdi[k] = W'($urandom);
            f_wr[k]  = ($urandom_range(0, 1) == 1);
            f_wrw[k] = W'($urandom);
         end
         if (model_buf.size() == 0 && $urandom_range(0, 1) == 1)
            tx_write(W'($urandom));
         run_frame(nw, ab);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
